watch_time_dp: RTL and testbench

//   Parametrised successor to the watch datapath: a 4-field time counter (sub-second, sec, min, hour).

---
 rtl/watch_pkg.sv | 21 ++
 rtl/watch_field_cnt.sv | 55 +++++
 rtl/watch_time_dp.sv | 161 ++++++++++++++++
 tb/tb_watch_time_dp.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Package: watch_pkg
// Shared constants for the watch time datapath.
//   - Field widths for the sub-second, seconds, minutes and hours counters.
//   - Moduli for the seconds and minutes fields.
//   - Encodings of the adjust field selector (i_adj_sel).
package watch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam int SEC_MAX = 60;
    localparam int MIN_MAX = 60;

    localparam logic [1:0] ADJ_SEL_NONE = 2'b00;
    localparam logic [1:0] ADJ_SEL_SEC  = 2'b01;
    localparam logic [1:0] ADJ_SEL_MIN  = 2'b10;
    localparam logic [1:0] ADJ_SEL_HOUR = 2'b11;

endpackage

// File: rtl/watch_field_cnt.sv
// Module: watch_field_cnt
// One modulo-MODULUS field of the watch time counter, stepping up or down.
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset, value <= clear_val
//   step       in   1      advance the field by one this cycle
//   dir        in   1      0: count up, 1: count down
//   load       in   1      value <= load_val (beats step)
//   load_val   in   WIDTH  load value, assumed already in range
//   clear      in   1      value <= clear_val (beats load and step)
//   clear_val  in   WIDTH  value used by clear and reset
//   value      out  WIDTH  registered field value
//   carry      out  1      combinational: step is wrapping the field this cycle
//                          (MODULUS-1 -> 0 going up, 0 -> MODULUS-1 going down)
module watch_field_cnt #(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic [WIDTH-1:0] clear_val,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic at_wrap;

    // The wrap point depends on direction: the top value going up, zero going down.
    assign at_wrap = dir ? (value == '0) : (value == TOP);
    assign carry   = step && at_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= clear_val;
        end else if (clear) begin
            value <= clear_val;
        end else if (load) begin
            value <= load_val;
        end else if (step) begin
            if (at_wrap) begin
                value <= dir ? TOP : '0;
            end else begin
                value <= dir ? (value - 1'b1) : (value + 1'b1);
            end
        end
    end

endmodule

// File: rtl/watch_time_dp.sv
// Module: watch_time_dp
// Watch time datapath: prescaled sub-second tick driving a sub-second / sec /
// min / hour counter chain, with run/pause, up/down count, clear, saturated
// parallel load and per-field adjust. The whole carry chain is combinational,
// so every field that changes on a tick changes on the same clock edge.
// Optional feature macro: WATCH_ALARM_EN (alarm registers and o_alarm pulse).
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   i_run                    1: count ticks, 0: paused with prescaler held at 0
//   i_dir                    0: up, 1: down (ticks and adjust)
//   i_clear                  pulse: fields to 0/0/0/HOUR_INIT, prescaler to 0
//   i_load                   pulse: load sec/min/hour (saturated), msec/prescaler to 0
//   i_load_sec/min/hour      load values
//   i_adj, i_adj_sel         pulse: step the selected field by one, no carry
//   msec, sec, min, hour     registered field values
//   o_sec_tick               pulse in the first cycle sec shows a tick/carry value
//   o_alarm                  alarm pulse (tied 0 without WATCH_ALARM_EN)
module watch_time_dp import watch_pkg::*; #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int SUB_MAX   = 100,
    parameter int HOUR_MAX  = 24,
    parameter int HOUR_INIT = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_dir,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [SEC_W-1:0]  i_load_sec,
    input  logic [MIN_W-1:0]  i_load_min,
    input  logic [HOUR_W-1:0] i_load_hour,
    input  logic              i_adj,
    input  logic [1:0]        i_adj_sel,
    output logic [MSEC_W-1:0] msec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              o_sec_tick,
    output logic              o_alarm
);

    localparam int PRESCALE = CLK_FREQ / TICK_HZ;
    localparam int PRESC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               tick_ok;
    logic               alarm_wr;
    logic               time_load;
    logic               adj_ok;
    logic               adj_any;
    logic               adj_sec, adj_min, adj_hour;
    logic               msec_co, sec_co, min_co;
    logic               hour_carry_unused;
    logic               sec_tick_q;
    logic [SEC_W-1:0]   load_sec;
    logic [MIN_W-1:0]   load_min;
    logic [HOUR_W-1:0]  load_hour;

    assign tick = i_run && (presc == PRESC_W'(PRESCALE - 1));

    // Event priority: clear > load > adjust > tick. Adjust only counts as an
    // event when it actually selects a field; a lost tick is simply dropped.
    assign adj_ok   = i_adj && !i_clear && !i_load;
    assign adj_any  = adj_ok && (i_adj_sel != ADJ_SEL_NONE);
    assign adj_sec  = adj_ok && (i_adj_sel == ADJ_SEL_SEC);
    assign adj_min  = adj_ok && (i_adj_sel == ADJ_SEL_MIN);
    assign adj_hour = adj_ok && (i_adj_sel == ADJ_SEL_HOUR);
    assign tick_ok  = tick && !i_clear && !i_load && !adj_any;

`ifdef WATCH_ALARM_EN
    // Loading with the hour selector writes the alarm instead of the time.
    assign alarm_wr = i_load && !i_clear && (i_adj_sel == ADJ_SEL_HOUR);
`else
    assign alarm_wr = 1'b0;
`endif
    assign time_load = i_load && !alarm_wr;

    assign load_sec  = (i_load_sec  > SEC_W'(SEC_MAX - 1))   ? SEC_W'(SEC_MAX - 1)   : i_load_sec;
    assign load_min  = (i_load_min  > MIN_W'(MIN_MAX - 1))   ? MIN_W'(MIN_MAX - 1)   : i_load_min;
    assign load_hour = (i_load_hour > HOUR_W'(HOUR_MAX - 1)) ? HOUR_W'(HOUR_MAX - 1) : i_load_hour;

    // Prescaler: free-runs while i_run, restarts a full period on pause,
    // clear and load. Adjust leaves it running.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (!i_run || i_clear || i_load || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    watch_field_cnt #(.MODULUS(SUB_MAX), .WIDTH(MSEC_W)) u_msec (
        .clk(clk), .rst(rst), .step(tick_ok), .dir(i_dir),
        .load(time_load), .load_val('0), .clear(i_clear), .clear_val('0),
        .value(msec), .carry(msec_co)
    );

    // Higher fields step on a tick carry or on their own adjust; carries are
    // gated by tick_ok so an adjust never ripples into the next field.
    watch_field_cnt #(.MODULUS(SEC_MAX), .WIDTH(SEC_W)) u_sec (
        .clk(clk), .rst(rst), .step((tick_ok && msec_co) || adj_sec), .dir(i_dir),
        .load(time_load), .load_val(load_sec), .clear(i_clear), .clear_val('0),
        .value(sec), .carry(sec_co)
    );

    watch_field_cnt #(.MODULUS(MIN_MAX), .WIDTH(MIN_W)) u_min (
        .clk(clk), .rst(rst), .step((tick_ok && sec_co) || adj_min), .dir(i_dir),
        .load(time_load), .load_val(load_min), .clear(i_clear), .clear_val('0),
        .value(min), .carry(min_co)
    );

    watch_field_cnt #(.MODULUS(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
        .clk(clk), .rst(rst), .step((tick_ok && min_co) || adj_hour), .dir(i_dir),
        .load(time_load), .load_val(load_hour), .clear(i_clear),
        .clear_val(HOUR_W'(HOUR_INIT)),
        .value(hour), .carry(hour_carry_unused)
    );

    // Registered alongside sec, so it is high exactly when the new sec appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= tick_ok && msec_co;
        end
    end
    assign o_sec_tick = sec_tick_q;

`ifdef WATCH_ALARM_EN
    logic [HOUR_W-1:0] alarm_hour;
    logic [MIN_W-1:0]  alarm_min;
    logic              tick_d;

    // tick_d marks the cycle after a tick, so only tick-driven arrival at the
    // alarm time fires; load/clear/adjust never set it.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hour <= '0;
            alarm_min  <= '0;
            tick_d     <= 1'b0;
        end else begin
            tick_d <= tick_ok;
            if (alarm_wr) begin
                alarm_hour <= load_hour;
                alarm_min  <= load_min;
            end
        end
    end

    assign o_alarm = tick_d && (hour == alarm_hour) && (min == alarm_min)
                     && (sec == '0) && (msec == '0);
`else
    assign o_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_watch_time_dp.sv
// Testbench: tb_watch_time_dp
// Directed test of watch_time_dp with CLK_FREQ=1000, TICK_HZ=100 (one tick
// every 10 clocks), SUB_MAX=100, HOUR_MAX=24, HOUR_INIT=12. Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// Covers the WATCH_ALARM_EN feature when that macro is defined.
module tb_watch_time_dp;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_run, i_dir, i_clear, i_load, i_adj;
    logic [5:0] i_load_sec, i_load_min;
    logic [4:0] i_load_hour;
    logic [1:0] i_adj_sel;
    logic [6:0] msec;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       o_sec_tick, o_alarm;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    watch_time_dp #(
        .CLK_FREQ(1000), .TICK_HZ(100), .SUB_MAX(100), .HOUR_MAX(24), .HOUR_INIT(12)
    ) dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_dir(i_dir), .i_clear(i_clear),
        .i_load(i_load), .i_load_sec(i_load_sec), .i_load_min(i_load_min),
        .i_load_hour(i_load_hour), .i_adj(i_adj), .i_adj_sel(i_adj_sel),
        .msec(msec), .sec(sec), .min(min), .hour(hour),
        .o_sec_tick(o_sec_tick), .o_alarm(o_alarm)
    );

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a one-cycle pulse of load/clear/adjust, then release it.
    task automatic applyStimulus(input logic load, input logic clear, input logic adj,
                                 input logic [1:0] sel, input logic [4:0] lhour,
                                 input logic [5:0] lmin, input logic [5:0] lsec);
        i_load = load;
        i_clear = clear;
        i_adj = adj;
        i_adj_sel = sel;
        i_load_hour = lhour;
        i_load_min = lmin;
        i_load_sec = lsec;
        waitCycles(1);
        i_load = 1'b0;
        i_clear = 1'b0;
        i_adj = 1'b0;
        i_adj_sel = 2'b00;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkTime(input string tag, input int h, input int m, input int s,
                             input int ms);
        checkOutput({tag, ".hour"}, 32'(hour), 32'(h));
        checkOutput({tag, ".min"},  32'(min),  32'(m));
        checkOutput({tag, ".sec"},  32'(sec),  32'(s));
        checkOutput({tag, ".msec"}, 32'(msec), 32'(ms));
    endtask

    initial begin
        rst = 1'b1;
        i_run = 1'b0;
        i_dir = 1'b0;
        i_clear = 1'b0;
        i_load = 1'b0;
        i_adj = 1'b0;
        i_adj_sel = 2'b00;
        i_load_sec = '0;
        i_load_min = '0;
        i_load_hour = '0;
        waitCycles(3);

        // Reset state
        checkTime("reset", 12, 0, 0, 0);
        checkOutput("reset.sec_tick", 32'(o_sec_tick), 32'd0);
        checkOutput("reset.alarm", 32'(o_alarm), 32'd0);

        // First tick after 10 clocks, first second after 1000 clocks
        rst = 1'b0;
        i_run = 1'b1;
        waitCycles(9);
        checkOutput("run.msec_before_tick", 32'(msec), 32'd0);
        waitCycles(1);
        checkOutput("run.msec_first_tick", 32'(msec), 32'd1);
        waitCycles(989);
        checkTime("run.pre_second", 12, 0, 0, 99);
        checkOutput("run.sec_tick_low", 32'(o_sec_tick), 32'd0);
        waitCycles(1);
        checkTime("run.first_second", 12, 0, 1, 0);
        checkOutput("run.sec_tick_high", 32'(o_sec_tick), 32'd1);
        waitCycles(1);
        checkOutput("run.sec_tick_pulse_end", 32'(o_sec_tick), 32'd0);

        // Full rollover 23:59:59.99 -> 0:00:00.00
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 5'd23, 6'd59, 6'd59);
        checkTime("load.rollover", 23, 59, 59, 0);
        waitCycles(990);
        checkTime("rollover.pre", 23, 59, 59, 99);
        waitCycles(10);
        checkTime("rollover.post", 0, 0, 0, 0);
        checkOutput("rollover.sec_tick", 32'(o_sec_tick), 32'd1);

        // Count down from 12:00:00.00
        i_dir = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 5'd12, 6'd0, 6'd0);
        waitCycles(10);
        checkTime("down.borrow", 11, 59, 59, 99);
        checkOutput("down.sec_tick", 32'(o_sec_tick), 32'd1);

        // Adjust: sec 0 down -> 59 without borrow, then hour up without carry
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 5'd10, 6'd30, 6'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 5'd0, 6'd0, 6'd0);
        checkTime("adj.sec_down", 10, 30, 59, 0);
        checkOutput("adj.no_sec_tick", 32'(o_sec_tick), 32'd0);
        i_dir = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 5'd0, 6'd0, 6'd0);
        checkTime("adj.hour_up", 11, 30, 59, 0);

        // Saturated load, then clear beats load in the same cycle
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 5'd30, 6'd5, 6'd63);
        checkTime("load.saturate", 23, 5, 59, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 5'd3, 6'd4, 6'd5);
        checkTime("clear.wins", 12, 0, 0, 0);

        // Pause at prescaler 5 for 50 clocks, resume needs a full period
        waitCycles(5);
        i_run = 1'b0;
        waitCycles(50);
        checkTime("pause.frozen", 12, 0, 0, 0);
        i_run = 1'b1;
        waitCycles(9);
        checkOutput("resume.msec_before", 32'(msec), 32'd0);
        waitCycles(1);
        checkOutput("resume.msec_step", 32'(msec), 32'd1);

`ifdef WATCH_ALARM_EN
        // Alarm write leaves the time alone
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 5'd12, 6'd1, 6'd0);
        checkTime("alarm.write_no_load", 12, 0, 0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 5'd12, 6'd0, 6'd59);
        waitCycles(990);
        checkTime("alarm.pre", 12, 0, 59, 99);
        checkOutput("alarm.pre_low", 32'(o_alarm), 32'd0);
        waitCycles(10);
        checkTime("alarm.reached", 12, 1, 0, 0);
        checkOutput("alarm.pulse", 32'(o_alarm), 32'd1);
        waitCycles(1);
        checkOutput("alarm.pulse_end", 32'(o_alarm), 32'd0);
        // Loading the alarm time directly must not fire
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 5'd12, 6'd1, 6'd0);
        checkTime("alarm.load_direct", 12, 1, 0, 0);
        checkOutput("alarm.load_no_pulse", 32'(o_alarm), 32'd0);
        waitCycles(1);
        checkOutput("alarm.load_no_pulse_next", 32'(o_alarm), 32'd0);
`else
        // Without the alarm, a load with the hour selector still loads time
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 5'd5, 6'd7, 6'd9);
        checkTime("noalarm.load_sel11", 5, 7, 9, 0);
        checkOutput("noalarm.alarm_low", 32'(o_alarm), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
